// File: rtl/rx_serial_7e1.sv
`default_nettype none
// ============================================================================
// Module      : rx_serial_7e1
// Description : Asynchronous serial receiver for 7E1 frames (start bit,
//               7 data bits LSB-first, even parity, 1 stop bit). The line is
//               oversampled with a bit-period counter and each bit is sampled
//               near the middle of its period. Parity and stop-bit status are
//               reported with every received character.
// Ports       : clock_i        system clock
//               reset_i        synchronous active-high reset
//               dado_serial_i  serial line, idle high, asynchronous
//               dados_ascii_o  last received character (bit 0 = first on line)
//               paridade_ok_o  1 = even parity held for last character
//               erro_quadro_o  1 = stop bit of last character sampled low
//               pronto_o       one-cycle strobe, outputs above just updated
//               ocupado_o      1 while a frame is being received
//               db_estado_o    current FSM state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_serial_7e1 #(
    parameter int M = 434,  // clocks per bit, >= 4
    parameter int N = 9     // bit-period counter width, 2**N > M
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       dado_serial_i,
    output logic [6:0] dados_ascii_o,
    output logic       paridade_ok_o,
    output logic       erro_quadro_o,
    output logic       pronto_o,
    output logic       ocupado_o,
    output logic [3:0] db_estado_o
);

    localparam logic [3:0] S_INICIAL        = 4'd0;
    localparam logic [3:0] S_CONFIRMA_START = 4'd1;
    localparam logic [3:0] S_RECEBE         = 4'd2;
    localparam logic [3:0] S_STOP           = 4'd3;
    localparam logic [3:0] S_FINAL          = 4'd4;

    // Last counter value of the half-bit wait and of a full bit period.
    localparam logic [N-1:0] C_HALF_LAST = N'(M / 2 - 1);
    localparam logic [N-1:0] C_BIT_LAST  = N'(M - 1);
    localparam logic [N-1:0] C_ONE       = N'(1);

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start edge.
    logic sync1_q;
    logic rx_q;

    logic [3:0]   state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   shift_q, shift_d;
    logic [6:0]   dados_q, dados_d;
    logic         par_ok_q, par_ok_d;
    logic         erro_q, erro_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b1;
            rx_q     <= 1'b1;
            state_q  <= S_INICIAL;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            dados_q  <= '0;
            par_ok_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            sync1_q  <= dado_serial_i;
            rx_q     <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            dados_q  <= dados_d;
            par_ok_q <= par_ok_d;
            erro_q   <= erro_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        dados_d  = dados_q;
        par_ok_d = par_ok_q;
        erro_d   = erro_q;

        case (state_q)
            S_INICIAL: begin
                if (!rx_q) begin
                    cnt_d   = '0;
                    state_d = S_CONFIRMA_START;
                end
            end

            S_CONFIRMA_START: begin
                // Re-check the line half a bit after the falling edge to
                // reject short low glitches on an idle line.
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_q ? S_INICIAL : S_RECEBE;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

            S_RECEBE: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d   = '0;
                    // Shift right with new bit at the top: after 8 samples
                    // the first line bit sits in bit 0 and parity in bit 7.
                    shift_d = {rx_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d    = '0;
                    dados_d  = shift_q[6:0];
                    par_ok_d = ~^shift_q;
                    erro_d   = ~rx_q;
                    state_d  = S_FINAL;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

            S_FINAL: begin
                // Leaves mid-stop-bit so an immediately following start
                // edge is still caught.
                state_d = S_INICIAL;
            end

            default: begin
                state_d = S_INICIAL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        pronto_o      = (state_q == S_FINAL);
        ocupado_o     = (state_q != S_INICIAL);
        db_estado_o   = state_q;
        dados_ascii_o = dados_q;
        paridade_ok_o = par_ok_q;
        erro_quadro_o = erro_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_serial_7e1.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_serial_7e1
// Description : Self-checking bench for rx_serial_7e1 (M = 8 clocks per bit).
//               Frames are built from their bit list; expected results come
//               from the frame contents with plain parity/stop arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_serial_7e1;

    localparam int M = 8;
    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       line;
    logic [6:0] dados;
    logic       par_ok;
    logic       erro;
    logic       pronto;
    logic       ocupado;
    logic [3:0] estado;

    int vectors;
    int miscompares;
    int cyc;

    typedef struct {
        logic [6:0] d;
        logic       p;
        logic       f;
        int         t;
    } ev_t;

    ev_t got[$];
    ev_t exp_q[$];

    rx_serial_7e1 #(.M(M), .N(N)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .dado_serial_i(line),
        .dados_ascii_o(dados),
        .paridade_ok_o(par_ok),
        .erro_quadro_o(erro),
        .pronto_o     (pronto),
        .ocupado_o    (ocupado),
        .db_estado_o  (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every delivered character, sampled away from the active edge.
    always @(negedge clk) begin
        if (pronto === 1'b1) begin
            ev_t e;
            e.d = dados;
            e.p = par_ok;
            e.f = erro;
            e.t = cyc;
            got.push_back(e);
        end
    end

    // Reference: even parity holds when data bits plus parity bit have an
    // even number of ones; a framing error is a low stop bit.
    function automatic ev_t model(input logic [6:0] d, input logic p, input logic s);
        ev_t e;
        e.d = d;
        e.p = (((^d) ^ p) == 1'b0);
        e.f = ~s;
        e.t = 0;
        return e;
    endfunction

    // Drive the first nbits bit periods of a frame, starting on a negedge.
    task automatic drive_frame(input logic [6:0] d, input logic p, input logic s,
                               input int nbits);
        logic [9:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            line = f[i];
            repeat (M) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        if ({dados, par_ok, erro, pronto, ocupado, estado} !== 15'd0) begin
            miscompares++;
            $display("FAIL %s: outputs={%h,%b,%b,%b,%b,%h} required all zero",
                     tag, dados, par_ok, erro, pronto, ocupado, estado);
        end
    endtask

    task automatic compare_queues(input string tag);
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_count: got %0d characters, required %0d",
                     tag, got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i].d !== exp_q[i].d || got[i].p !== exp_q[i].p ||
                got[i].f !== exp_q[i].f) begin
                miscompares++;
                $display("FAIL %s[%0d]: got d=%h par_ok=%b erro=%b, required d=%h par_ok=%b erro=%b",
                         tag, i, got[i].d, got[i].p, got[i].f,
                         exp_q[i].d, exp_q[i].p, exp_q[i].f);
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        line = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset_release");
        idle(4);
    endtask

    task automatic test_basic();
        int t0;
        got.delete();
        exp_q.delete();
        t0 = cyc;
        drive_frame(7'h41, 1'b0, 1'b1, 10);
        exp_q.push_back(model(7'h41, 1'b0, 1'b1));
        idle(2 * M);
        compare_queues("basic");
        if (got.size() > 0) begin
            vectors++;
            if (got[0].t - t0 < 78 || got[0].t - t0 > 80) begin
                miscompares++;
                $display("FAIL basic_latency: got %0d clocks, required 79 +-1",
                         got[0].t - t0);
            end
        end
    endtask

    task automatic test_back_to_back();
        got.delete();
        exp_q.delete();
        drive_frame(7'h43, 1'b1, 1'b1, 10);
        drive_frame(7'h7F, 1'b1, 1'b1, 10);
        exp_q.push_back(model(7'h43, 1'b1, 1'b1));
        exp_q.push_back(model(7'h7F, 1'b1, 1'b1));
        idle(2 * M);
        compare_queues("back_to_back");
    endtask

    task automatic test_parity_error();
        got.delete();
        exp_q.delete();
        drive_frame(7'h41, 1'b1, 1'b1, 10);
        exp_q.push_back(model(7'h41, 1'b1, 1'b1));
        idle(2 * M);
        compare_queues("parity_error");
    endtask

    task automatic test_frame_error();
        got.delete();
        exp_q.delete();
        drive_frame(7'h55, 1'b0, 1'b0, 10);
        exp_q.push_back(model(7'h55, 1'b0, 1'b0));
        idle(3 * M);
        compare_queues("frame_error");
    endtask

    task automatic test_glitch();
        logic seen_busy;
        logic seen_idle;
        got.delete();
        seen_busy = 1'b0;
        seen_idle = 1'b0;
        line = 1'b0;
        repeat (2) @(negedge clk);
        line = 1'b1;
        for (int i = 0; i < 8 && !seen_busy; i++) begin
            @(negedge clk);
            if (ocupado === 1'b1) seen_busy = 1'b1;
        end
        vectors++;
        if (seen_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy: ocupado=%b, required 1 within 8 clocks", seen_busy);
        end
        for (int i = 0; i < 12 && !seen_idle; i++) begin
            @(negedge clk);
            if (ocupado === 1'b0) seen_idle = 1'b1;
        end
        vectors++;
        if (seen_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_idle: ocupado stayed 1, required 0 within 12 clocks");
        end
        idle(10 * M);
        vectors++;
        if (got.size() !== 0) begin
            miscompares++;
            $display("FAIL glitch_pronto: got %0d characters, required 0", got.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        got.delete();
        exp_q.delete();
        // Start bit plus data bits 0..2, then partway into data bit 3.
        drive_frame(7'h6A, 1'b0, 1'b1, 4);
        line = 1'b1;
        repeat (M / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset_mid_frame");
        idle(2 * M);
        drive_frame(7'h30, 1'b0, 1'b1, 10);
        exp_q.push_back(model(7'h30, 1'b0, 1'b1));
        idle(2 * M);
        compare_queues("reset_mid_frame");
    endtask

    task automatic test_random();
        logic [6:0] d;
        logic       p;
        logic       s;
        got.delete();
        exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            d = 7'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(0, 4) != 0);
            drive_frame(d, p, s, 10);
            exp_q.push_back(model(d, p, s));
            // A low stop bit needs a real high gap before the next start.
            if (s) idle($urandom_range(0, M));
            else   idle(2 * M);
        end
        idle(3 * M);
        compare_queues("random");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        line        = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity_error();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
